// File: rtl/bp_pkg.sv
// Shared constants for the 2-bit branch predictor.
// Counter encodings and IF-stage next-PC mux select codes.
package bp_pkg;

  localparam int CTR_W = 2;

  localparam logic [CTR_W-1:0] SNT = 2'b00;
  localparam logic [CTR_W-1:0] WNT = 2'b01;
  localparam logic [CTR_W-1:0] WT  = 2'b10;
  localparam logic [CTR_W-1:0] ST  = 2'b11;

  localparam logic [2:0] PC_SEL_SEQ   = 3'b001;
  localparam logic [2:0] PC_SEL_TAKEN = 3'b010;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
// Pure combinational; the counter table lives in the top level.
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic [CTR_W-1:0] state,
  input  logic             taken,
  output logic [CTR_W-1:0] next
);

  always_comb begin
    next = state;
    unique case (1'b1)
      taken && (state != ST):   next = state + 2'd1;
      !taken && (state != SNT): next = state - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bp_2bit_predictor.sv
// Bimodal 2-bit branch predictor driving the IF next-PC mux select.
// Define BP_GSHARE_EN to XOR a global history register into the index.
module bp_2bit_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [XLEN-1:0]       lookup_pc,
  input  logic                  flush,
  input  logic                  upd_valid,
  input  logic [XLEN-1:0]       upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_mispredict,
  input  logic [INDEX_BITS-1:0] upd_hist,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [2:0]            pc_sel,
  output logic [INDEX_BITS-1:0] pred_hist,
  output logic [CNT_W-1:0]      lookup_count,
  output logic [CNT_W-1:0]      mispredict_count
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [CTR_W-1:0]      tbl_q [DEPTH];
  logic [CTR_W-1:0]      tbl_d [DEPTH];
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] up_idx;
  logic [CTR_W-1:0]      up_next;
  logic                  lk_acc;

  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [2:0]            pc_sel_q, pc_sel_d;
  logic [INDEX_BITS-1:0] pred_hist_q, pred_hist_d;
  logic [CNT_W-1:0]      lookup_count_q, lookup_count_d;
  logic [CNT_W-1:0]      misp_count_q, misp_count_d;

  assign lk_acc = lookup_valid & ~flush;

`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2] ^ ghr_q;
  assign up_idx = upd_pc[INDEX_BITS+1:2] ^ upd_hist;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid)
      ghr_d = {ghr_q[INDEX_BITS-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end

  assign pred_hist_d = lk_acc ? ghr_q : '0;

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[XLEN-1:INDEX_BITS+2],
                         lookup_pc[1:0],
                         upd_pc[XLEN-1:INDEX_BITS+2],
                         upd_pc[1:0]};
`else
  assign lk_idx      = lookup_pc[INDEX_BITS+1:2];
  assign up_idx      = upd_pc[INDEX_BITS+1:2];
  assign pred_hist_d = '0;

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[XLEN-1:INDEX_BITS+2],
                         lookup_pc[1:0],
                         upd_pc[XLEN-1:INDEX_BITS+2],
                         upd_pc[1:0],
                         upd_hist};
`endif

  bp_sat_counter2 u_ctr (
    .state (tbl_q[up_idx]),
    .taken (upd_taken),
    .next  (up_next)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      tbl_d[i] = tbl_q[i];
    if (upd_valid)
      tbl_d[up_idx] = up_next;
  end

  // Lookup reads the table as it stands before this edge's update.
  always_comb begin
    pred_valid_d   = lk_acc;
    pred_taken_d   = lk_acc & tbl_q[lk_idx][CTR_W-1];
    pc_sel_d       = pred_taken_d ? PC_SEL_TAKEN : PC_SEL_SEQ;
    lookup_count_d = lookup_count_q + CNT_W'(lk_acc);
    misp_count_d   = misp_count_q
                   + CNT_W'(upd_valid & upd_mispredict);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        tbl_q[i] <= WNT;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pc_sel_q       <= PC_SEL_SEQ;
      pred_hist_q    <= '0;
      lookup_count_q <= '0;
      misp_count_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        tbl_q[i] <= tbl_d[i];
      pred_valid_q   <= pred_valid_d;
      pred_taken_q   <= pred_taken_d;
      pc_sel_q       <= pc_sel_d;
      pred_hist_q    <= pred_hist_d;
      lookup_count_q <= lookup_count_d;
      misp_count_q   <= misp_count_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pc_sel           = pc_sel_q;
  assign pred_hist        = pred_hist_q;
  assign lookup_count     = lookup_count_q;
  assign mispredict_count = misp_count_q;

endmodule

// File: doc/bp_2bit_predictor.md
Name: bp_2bit_predictor

Overview:
- Branch direction predictor that drives the 3-bit select of the IF-stage next-PC multiplexer.
- The multiplexer's A input is PC+4; its B input is the branch target.
- Holds a table of 2-bit saturating counters indexed by fetch PC and returns a registered taken/not-taken prediction encoded as the mux select.
- Counters are trained from the EX-stage branch resolution port; 16-bit performance counters are included.

Parameters:
- INDEX_BITS, 6, log2 of table depth (64 entries); index = pc[INDEX_BITS+1:2].
- XLEN, 32, PC width.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  IF-stage lookup request.
- lookup_pc  in  XLEN  fetch PC.
- flush  in  1  pipeline flush; kills the in-flight prediction.
- upd_valid  in  1  EX-stage resolved branch.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  EX found the prediction wrong.
- upd_hist  in  INDEX_BITS  history returned with the branch (ignored without GSHARE_EN).
- pred_valid  out  1  prediction valid.
- pred_taken  out  1  predicted direction.
- pc_sel  out  3  mux select: 3'b001 = A (PC+4), 3'b010 = B (target).
- pred_hist  out  INDEX_BITS  history snapshot used for this prediction (0 without GSHARE_EN).
- lookup_count  out  CNT_W  number of accepted lookups.
- mispredict_count  out  CNT_W  number of mispredictions.

Behaviour:
- Reset is asynchronous on rst_n low:
  - every table entry = WNT (2'b01);
  - pred_valid = 0, pred_taken = 0, pc_sel = 3'b001, pred_hist = 0;
  - both counters = 0; GHR = 0.
- Counter states: SNT 00, WNT 01, WT 10, ST 11. Prediction is taken iff counter[1] = 1.
- Lookup latency is 1 cycle. If lookup_valid is high in cycle N, then in N+1:
  - pred_valid = 1;
  - pred_taken = MSB of the indexed entry as it was at edge N;
  - pc_sel = pred_taken ? 3'b010 : 3'b001.
- With lookup_valid low: pred_valid = 0 and pc_sel = 3'b001 next cycle.
- pc_sel is always one of 3'b001 or 3'b010, never any other code.
- Update on upd_valid (edge-registered):
  - upd_taken = 1 increments the entry at upd_pc, saturating at ST (11).
  - upd_taken = 0 decrements it, saturating at SNT (00).
  - No wrap-around in either direction.
- Same-index read and update in one cycle: the read returns the pre-update value (no bypass). The update lands at the same edge.
- Flush:
  - flush = 1 forces pred_valid = 0 and pc_sel = 3'b001 at the next edge, regardless of lookup_valid.
  - A lookup in the flush cycle is not counted.
  - Updates in the flush cycle are still applied.
- Counters:
  - lookup_count increments on each accepted lookup (lookup_valid & !flush).
  - mispredict_count increments on upd_valid & upd_mispredict.
  - Both wrap modulo 2^CNT_W.
- Reset mid-operation discards the in-flight prediction and all trained state immediately, without waiting for a clock edge.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - an INDEX_BITS global history register (GHR) shifts left with upd_taken in the LSB on every upd_valid;
  - lookup index = pc[INDEX_BITS+1:2] XOR GHR;
  - pred_hist = GHR sampled at lookup;
  - update index = upd_pc[INDEX_BITS+1:2] XOR upd_hist.
- Not defined:
  - no GHR, and pure PC indexing;
  - pred_hist is tied to 0 and upd_hist is unused.

Decomposition:
- Package bp_pkg holds:
  - counter state localparams SNT/WNT/WT/ST;
  - PC_SEL_SEQ = 3'b001 and PC_SEL_TAKEN = 3'b010;
  - the counter width (2).
- Sub-module bp_sat_counter2: a purely combinational next-state function (state, taken -> next). The table and registers stay in the top module.

Test Plan:
- Reset, then lookup at PC 0x0000_0040 -> next cycle pred_valid = 1, pred_taken = 0, pc_sel = 3'b001 (entry at WNT).
- One taken update at PC 0x40, then lookup 0x40 -> pc_sel = 3'b010. Three further taken updates, then one not-taken -> still taken (ST to WT). A second not-taken -> pc_sel = 3'b001.
- Six not-taken updates at PC 0x80 then one taken -> entry at WNT and prediction not-taken, which proves saturation at SNT with no wrap.
- Lookup and taken update to the same index (0x40, entry WNT) in one cycle -> prediction not-taken (old value). A repeat lookup next cycle -> taken.
- flush asserted with lookup_valid -> pred_valid = 0 and pc_sel = 3'b001 next cycle, with lookup_count unchanged. 3 mispredicts -> mispredict_count = 3. Assert rst_n low mid-run -> all outputs return to reset values without a clock edge.
- With BP_GSHARE_EN: train PC 0x40 taken with history 6'b000001 -> lookup 0x40 with GHR = 0 returns not-taken, and with GHR = 6'b000001 returns taken.
